// File: rtl/lfsr_rnd_pkg.sv
// Shared types and constants for the lfsr_rnd_gen pseudo-random word source.
// Holds the WARM/RUN state type, default polynomial/seed and counter sizing.
package lfsr_rnd_pkg;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } lfsr_state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hbed4dead;

  // Warm-up counter width: enough bits to hold WARMUP, never narrower than 1.
  function automatic int cnt_width(input int warmup);
    int w;
    w = $clog2(warmup + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lfsr_rnd_step.sv
// Purely combinational single Galois LFSR step; the top chains STEPS of these
// so one advance covers several steps in a single cycle.
module lfsr_rnd_step
  import lfsr_rnd_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // The MSB feeds back into bit 0 and, through the tap mask, into every tapped bit.
  assign nxt = {cur[WIDTH-2:0] ^ (POLY[WIDTH-1:1] & {(WIDTH-1){cur[WIDTH-1]}}),
                cur[WIDTH-1]};

endmodule

// File: rtl/lfsr_rnd_gen.sv
// Parametrised Galois-LFSR word source with reseeding, warm-up and valid/ready output.
// Optional zero-state health check and sticky O_error enabled by LFSR_RND_HEALTH_EN.
module lfsr_rnd_gen
  import lfsr_rnd_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEFAULT_SEED),
  parameter int               STEPS  = 1,
  parameter int               WARMUP = 4
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_seed_we,
  input  logic [WIDTH-1:0] I_seed,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [WIDTH-1:0] O_rnd,
  output logic             O_error
);

  localparam int             CW         = cnt_width(WARMUP);
  localparam logic [CW-1:0]  WARMUP_CNT = CW'(WARMUP);
  localparam lfsr_state_e    START_ST   = lfsr_state_e'((WARMUP == 0) ? RUN : WARM);

  logic [WIDTH-1:0]           state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  lfsr_state_e                fsm_q, fsm_d;
  logic                       zero_hit;
  logic [STEPS:0][WIDTH-1:0]  chain;

  assign chain[0] = state_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    lfsr_rnd_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_step (
      .cur (chain[i]),
      .nxt (chain[i+1])
    );
  end

`ifdef LFSR_RND_HEALTH_EN
  logic error_q;

  assign zero_hit = (state_q == '0);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      error_q <= 1'b0;
    end else if (zero_hit) begin
      error_q <= 1'b1;
    end
  end

  assign O_error = error_q;
`else
  assign zero_hit = 1'b0;
  assign O_error  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    fsm_d   = fsm_q;
    if (zero_hit) begin
      state_d = SEED;
      cnt_d   = WARMUP_CNT;
      fsm_d   = START_ST;
    end else if (I_seed_we) begin
      // A seed load wins over a same-cycle handshake; that word stays unconsumed.
      state_d = (I_seed == '0) ? SEED : I_seed;
      cnt_d   = WARMUP_CNT;
      fsm_d   = START_ST;
    end else if (fsm_q == WARM) begin
      state_d = chain[STEPS];
      cnt_d   = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) fsm_d = RUN;
    end else if (I_ready) begin
      state_d = chain[STEPS];
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!I_reset_n) begin
      state_q <= SEED;
      cnt_q   <= WARMUP_CNT;
      fsm_q   <= START_ST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fsm_q   <= fsm_d;
    end
  end

  assign O_valid = (fsm_q == RUN);
  assign O_rnd   = state_q;

endmodule

// File: tb/tb_lfsr_rnd_gen.sv
// Self-checking bench for lfsr_rnd_gen: default, WARMUP=0 and 16-bit/16-step instances
// against a word-level Galois model; health checks run when LFSR_RND_HEALTH_EN is defined.
module tb_lfsr_rnd_gen;

  localparam logic [63:0] POLY32 = 64'h80200003;
  localparam logic [63:0] SEED32 = 64'hbed4dead;
  localparam logic [63:0] POLY16 = 64'h0000b400;
  localparam logic [63:0] SEED16 = 64'h0000dead;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        seed_we_a, ready_a, valid_a, err_a;
  logic [31:0] seed_a, rnd_a;
  logic        seed_we_b, ready_b, valid_b, err_b;
  logic [31:0] seed_b, rnd_b;
  logic        seed_we_c, ready_c, valid_c, err_c;
  logic [15:0] seed_c, rnd_c;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_a, exp_c, sx, sy;
  logic        r;

  lfsr_rnd_gen dut_a (
    .I_clk(clk), .I_reset_n(rst_n), .I_seed_we(seed_we_a), .I_seed(seed_a),
    .O_valid(valid_a), .I_ready(ready_a), .O_rnd(rnd_a), .O_error(err_a)
  );

  lfsr_rnd_gen #(.WARMUP(0)) dut_b (
    .I_clk(clk), .I_reset_n(rst_n), .I_seed_we(seed_we_b), .I_seed(seed_b),
    .O_valid(valid_b), .I_ready(ready_b), .O_rnd(rnd_b), .O_error(err_b)
  );

  lfsr_rnd_gen #(.WIDTH(16), .POLY(16'hb400), .STEPS(16)) dut_c (
    .I_clk(clk), .I_reset_n(rst_n), .I_seed_we(seed_we_c), .I_seed(seed_c),
    .O_valid(valid_c), .I_ready(ready_c), .O_rnd(rnd_c), .O_error(err_c)
  );

  // Textbook Galois shift: shift left, and if a 1 fell out of the top, fold in the taps.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] poly,
                                            input int w);
    logic [63:0] mask;
    logic [63:0] res;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    res  = (s << 1) & mask;
    if (s[w-1]) res = (res ^ (poly & mask)) | 64'd1;
    return res;
  endfunction

  function automatic logic [63:0] adv(input logic [63:0] s, input logic [63:0] poly,
                                      input int w, input int n);
    logic [63:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = lfsr_step(v, poly, w);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    seed_we_a = 1'b0; seed_a = '0; ready_a = 1'b0;
    seed_we_b = 1'b0; seed_b = '0; ready_b = 1'b0;
    seed_we_c = 1'b0; seed_c = '0; ready_c = 1'b0;
    @(negedge clk);

    check("rst_valid_a", valid_a, 0);
    check("rst_rnd_a", rnd_a, SEED32);
    check("rst_err_a", err_a, 0);
    check("rst_valid_b", valid_b, 1);
    check("rst_rnd_b", rnd_b, SEED32);
    check("rst_valid_c", valid_c, 0);
    check("rst_rnd_c", rnd_c, SEED16);

    rst_n = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("warm_valid_a", valid_a, (i == 4));
      check("warm_valid_c", valid_c, (i == 4));
      if (i == 1) begin
        check("b_first_step", rnd_b, 64'hfd89bd59);
        check("b_valid_run", valid_b, 1);
        ready_b = 1'b0;
      end else begin
        check("b_hold", rnd_b, 64'hfd89bd59);
      end
    end
    exp_a = adv(SEED32, POLY32, 32, 4);
    exp_c = adv(SEED16, POLY16, 16, 64);
    check("first_word_a", rnd_a, exp_a);
    check("first_word_c", rnd_c, exp_c);
    ready_c = 1'b0;

    // Random consumer pacing in RUN.
    for (int i = 0; i < 200; i++) begin
      check("run_word_a", rnd_a, exp_a);
      check("run_valid_a", valid_a, 1);
      r = 1'($urandom_range(0, 1));
      ready_a = r;
      tick();
      if (r) exp_a = lfsr_step(exp_a, POLY32, 32);
    end

    // Stall for 10 cycles, then exactly one advance.
    ready_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_word_a", rnd_a, exp_a);
    end
    ready_a = 1'b1;
    tick();
    exp_a = lfsr_step(exp_a, POLY32, 32);
    ready_a = 1'b0;
    check("one_adv_a", rnd_a, exp_a);
    tick();
    check("one_adv_hold_a", rnd_a, exp_a);

    // Zero seed with a same-cycle handshake: the seed wins, SEED is substituted.
    seed_we_a = 1'b1; seed_a = '0; ready_a = 1'b1;
    tick();
    seed_we_a = 1'b0;
    check("seed_drop_valid_a", valid_a, 0);
    check("zero_seed_rnd_a", rnd_a, SEED32);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("zseed_valid_a", valid_a, (i == 4));
    end
    check("zseed_word_a", rnd_a, adv(SEED32, POLY32, 32, 4));

    seed_we_a = 1'b1; seed_a = 32'hbed4dead; ready_a = 1'b0;
    tick();
    seed_we_a = 1'b0;
    repeat (4) tick();
    check("eseed_valid_a", valid_a, 1);
    check("eseed_word_a", rnd_a, adv(SEED32, POLY32, 32, 4));

    // Reseed during WARM restarts the warm-up.
    sx = {32'd0, $urandom | 32'd1};
    sy = {32'd0, $urandom | 32'd1};
    seed_we_a = 1'b1; seed_a = sx[31:0];
    tick();
    seed_we_a = 1'b0;
    tick();
    tick();
    check("restart_mid_valid_a", valid_a, 0);
    seed_we_a = 1'b1; seed_a = sy[31:0];
    tick();
    seed_we_a = 1'b0;
    check("restart_load_a", rnd_a, sy);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("restart_valid_a", valid_a, (i == 4));
    end
    check("restart_word_a", rnd_a, adv(sy, POLY32, 32, 4));

    // WARMUP=0: zero seed plus handshake keeps O_valid high and discards the handshake.
    seed_we_b = 1'b1; seed_b = '0; ready_b = 1'b1;
    tick();
    seed_we_b = 1'b0;
    check("b_seed_valid", valid_b, 1);
    check("b_seed_rnd", rnd_b, SEED32);
    tick();
    ready_b = 1'b0;
    check("b_after_seed", rnd_b, 64'hfd89bd59);

`ifdef LFSR_RND_HEALTH_EN
    force dut_a.state_q = '0;
    #1;
    release dut_a.state_q;
    check("health_zero_seen", rnd_a, 0);
    @(posedge clk);
    @(negedge clk);
    check("health_err_a", err_a, 1);
    check("health_reload_a", rnd_a, SEED32);
    check("health_valid_a", valid_a, 0);
    repeat (4) tick();
    check("health_sticky_a", err_a, 1);
`else
    check("no_health_err_a", err_a, 0);
    repeat (4) tick();
`endif

    // Asynchronous reset in RUN, observed before any clock edge.
    check("pre_reset_valid_a", valid_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid_a", valid_a, 0);
    check("async_rnd_a", rnd_a, SEED32);
    check("async_err_a", err_a, 0);
    check("async_rnd_b", rnd_b, SEED32);
    check("async_valid_b", valid_b, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 16-bit, 16 steps per word: sustained throughput over 2^16 words.
    ready_c = 1'b1;
    repeat (4) tick();
    exp_c = adv(SEED16, POLY16, 16, 64);
    check("c_first_word", rnd_c, exp_c);
    for (int i = 0; i < 65536; i++) begin
      tick();
      exp_c = adv(exp_c, POLY16, 16, 16);
      check("c_word", rnd_c, exp_c);
      check("c_nonzero", (rnd_c == 16'd0), 0);
    end
    ready_c = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_rnd_gen.md
# lfsr_rnd_gen

Parametrised Galois-LFSR pseudo-random word source for the CPU core. It generalises the fixed 32-bit generator in width, polynomial, seed and steps-per-word. It adds run-time reseeding, a post-seed warm-up phase and a valid/ready output handshake, so consumers such as address-randomisation and tag logic can pull words at their own rate. It sits next to the core's security units and is clocked in the core clock domain.

## Interface
- WIDTH, 32: state and output width, 8..64.
- POLY, 32'h80200003 (WIDTH bits): feedback tap mask; bit WIDTH-1 must be 1.
- SEED, 32'hbed4dead (WIDTH bits): reset seed and zero-seed substitute; must be nonzero.
- STEPS, 1: LFSR steps applied per advance, 1..WIDTH.
- WARMUP, 4: advances performed after reset/reseed before output is valid, 0..255.
- I_clk, in, 1: clock, rising edge.
- I_reset_n, in, 1: asynchronous, active-low reset.
- I_seed_we, in, 1: load I_seed this cycle.
- I_seed, in, WIDTH: new seed.
- O_valid, out, 1: O_rnd holds a fresh word.
- I_ready, in, 1: consumer takes O_rnd when O_valid is 1.
- O_rnd, out, WIDTH: current LFSR state.
- O_error, out, 1: sticky flag, set on all-zero state detection (macro-gated).

## Operation
- One step: next = {s[WIDTH-2:0] ^ (POLY[WIDTH-1:1] & {WIDTH-1{s[WIDTH-1]}}), s[WIDTH-1]}.
- One advance is STEPS chained steps, computed combinationally in the same cycle.
- States: WARM and RUN.
- WARM:
  - Advances every cycle and decrements the warm-up counter; O_valid=0.
  - Moves to RUN on the cycle the counter reaches 0.
  - With WARMUP=0, WARM is skipped entirely.
- RUN:
  - O_valid=1.
  - On O_valid&&I_ready, advances once. The new word appears next cycle and O_valid stays 1.
  - With no handshake, the state holds and O_rnd is stable.
- Seed load (I_seed_we=1):
  - Has priority over a handshake in the same cycle; that handshake is discarded, so the word is not consumed.
  - Loads I_seed, or SEED if I_seed==0. Reloads the counter with WARMUP and enters WARM (or RUN if WARMUP=0).
  - O_valid falls the next cycle when WARMUP>0.
  - A seed load during WARM restarts the warm-up.
- The state register never holds 0 under normal operation.

## Timing
- Reset values: state=SEED, counter=WARMUP, O_valid=0 (1 if WARMUP=0), O_error=0.
- Reset asserted mid-operation clears everything immediately, with no clock needed.
- First valid word arrives WARMUP cycles after reset release; that word equals SEED advanced WARMUP times.
- Handshake-to-next-word latency: 1 cycle. Sustained throughput: 1 word/cycle while I_ready=1.
- Seed-to-valid latency: WARMUP cycles; the first valid word is the seed advanced WARMUP times.
- O_rnd is registered; there is no combinational path from any input to O_rnd.
- O_valid is registered; there is no combinational path from I_ready to O_valid.

## Configuration
- LFSR_RND_HEALTH_EN defined:
  - A comparator flags state==0, for example after a single-event upset.
  - That cycle: O_error is set (sticky until reset), the state reloads SEED, and the block enters WARM.
- Undefined: the comparator is absent and O_error is tied to 0.

## Structure
- lfsr_rnd_pkg holds:
  - the state enum {WARM, RUN};
  - the default POLY and SEED constants;
  - the function computing the counter width, $clog2(WARMUP+1), minimum 1.
- Sub-module lfsr_rnd_step: purely combinational single Galois step, parameters WIDTH and POLY, instantiated STEPS times in a generate chain.

## Test plan
- Defaults, reset release, I_ready=1:
  - O_valid rises 4 cycles after release;
  - outputs match a reference-model sequence from 0xbed4dead; one step of 0xbed4dead gives 0xfd89bd59.
- WARMUP=0, STEPS=1: first cycle after reset O_rnd=0xbed4dead with O_valid=1; after one handshake O_rnd=0xfd89bd59.
- I_ready held 0 for 10 cycles in RUN: O_rnd is unchanged; the next handshake advances exactly once.
- Seed load edge cases:
  - I_seed_we=1 with I_seed=0 behaves identically to loading 0xbed4dead;
  - I_seed_we and a handshake in the same cycle: the seed wins and O_valid drops next cycle.
- WIDTH=16, POLY=16'hB400, STEPS=16: consecutive words match the model advanced 16 steps each; no word is 0 over 2^16 words.
- Health (LFSR_RND_HEALTH_EN): force the state to 0 → O_error=1 next cycle and the state equals SEED; assert I_reset_n low mid-RUN → all outputs return to reset values asynchronously.
